enc_round_engine: RTL and testbench
===================================

# enc_round_engine

Iterative AES forward-cipher datapath: loads a 128-bit plaintext block, applies the initial AddRoundKey, then one full round per clock, and delivers the ciphertext with a one-cycle `done` pulse. It is the encryption counterpart of the inverse-cipher round datapath. It sits between the controller, which issues `start`/`abort`/`mode`, and the expanded-key store, which returns `round_key` for the `key_idx` this block drives.

## Interface
- No parameters. Round count is selected by `mode` and the `AES_ENC_MODE256_EN` macro.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  accept `plain` when `ready`=1.
- `abort`  in  1  synchronous cancel; returns to IDLE, no `done`.
- `mode`  in  2  0: AES-128 (Nr=10), 1: AES-192 (Nr=12), 2: AES-256 (Nr=14), 3: treated as 0.
- `plain`  in  128  plaintext block; byte 0 is `[127:120]`, column-major.
- `round_key`  in  128  round key for the current `key_idx`; combinational from the key store in the same cycle.
- `key_idx`  out  4  round-key index requested this cycle.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in ROUND and FINAL.
- `done`  out  1  one-cycle pulse; `cipher` is valid from this cycle onward.
- `cipher`  out  128  ciphertext; holds its value until the next `done`, or until `abort`/`rst` clears it.

## Operation
- States: IDLE, ROUND, FINAL. The round counter `rnd` is 4 bits. `Nr` is latched from `mode` when `start` is accepted and does not change mid-block.
- IDLE: `key_idx`=0. On `start`, the block sets `state` <= `plain` ^ `round_key`, `rnd` <= 1, and moves to ROUND.
- ROUND: `key_idx`=`rnd`. The block sets `state` <= MixColumns(ShiftRows(SubBytes(`state`))) ^ `round_key` and increments `rnd`. It moves to FINAL when `rnd`==Nr-1; otherwise it stays in ROUND.
- FINAL: `key_idx`=Nr. The block sets `cipher` <= ShiftRows(SubBytes(`state`)) ^ `round_key` (no MixColumns), sets `done` <= 1, and moves to IDLE.
- Datapath:
  - SubBytes uses 16 combinational forward S-boxes.
  - MixColumns uses the GF(2^8) polynomial x^8+x^4+x^3+x+1 with the {02,03,01,01} circulant.
- `start` while `busy`=1: ignored; the block in flight is unaffected.
- `abort`, in any state: next state IDLE, `cipher` <= 0, `done` <= 0, `rnd` <= 0. `abort` has priority over `start` in the same cycle.
- `start` in the cycle `done` is high: accepted, because the block is in IDLE. `cipher` keeps the previous result until the new block's `done`.
- `rst` has priority over everything. Reset values: `cipher`=0, `done`=0, `busy`=0, `ready`=1, `key_idx`=0, internal `state`=0, `rnd`=0.
- `rst` mid-block: the block is discarded and no `done` follows.

## Timing
- Start accepted at edge E0. ROUND occupies cycles E0+1 … E0+Nr-1. FINAL occupies cycle E0+Nr.
- `done` and the new `cipher` are visible after edge E0+Nr+1, i.e. latency Nr+1 cycles: 11 / 13 / 15 for AES-128 / -192 / -256.
- Throughput: one block per Nr+1 cycles. Back-to-back starts are possible with no idle gap.
- `key_idx` is a registered-state decode. `round_key` must settle within the same cycle; the key-store read is combinational.
- `ready` = !`busy` at all times.

## Configuration
- `AES_ENC_MODE256_EN` defined: `mode` is honoured and Nr ∈ {10, 12, 14}.
- `AES_ENC_MODE256_EN` undefined:
  - `mode` is ignored and Nr=10 always.
  - `rnd` compare logic is reduced to the constant 9.
  - `key_idx` never exceeds 10.

## Test plan
- Reset: assert `rst` for 2 cycles -> `cipher`=0, `done`=0, `ready`=1, `busy`=0, `key_idx`=0.
- AES-128 (FIPS-197 C.1): key 000102…0f, plain 00112233445566778899aabbccddeeff, `mode`=0.
  - `done` 11 cycles after `start`.
  - `cipher`=69c4e0d86a7b0430d8cdb78070b4c55a.
  - `key_idx` sequence 0,1,…,10.
- AES-192 and AES-256 (macro on): key 00…17 and key 00…1f respectively, same plaintext.
  - AES-192: `cipher`=dda97ca4864cdfe06eaf70a0ec0d7191 at 13 cycles.
  - AES-256: `cipher`=8ea2b7ca516745bfeafc49904b496089 at 15 cycles.
- `start` pulsed at cycle 5 of an AES-128 block -> ignored; a single `done` at cycle 11 with the C.1 result.
- `abort` at cycle 4 of a block -> IDLE next cycle, `cipher`=0, no `done`. A following `start` completes normally.
- Back-to-back: second `start` in the `done` cycle -> second `done` exactly 11 cycles later. The first `cipher` holds until then.

Source files
------------

// File: rtl/enc_round_engine.sv
// Iterative AES forward cipher: initial AddRoundKey on load, one round per clock, final round without MixColumns.
// Define AES_ENC_MODE256_EN to honour mode_i (AES-128/192/256); otherwise Nr is fixed at 10.
module enc_round_engine (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [1:0]   mode_i,
    input  logic [127:0] plain_i,
    input  logic [127:0] round_key_i,
    output logic [3:0]   key_idx_o,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] cipher_o
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} fsm_t;

    fsm_t         fsm_q;
    logic [127:0] blk_q;
    logic [127:0] cipher_q;
    logic [3:0]   rnd_q;
    logic         done_q;
    logic [3:0]   nr_cur;
    logic [3:0]   last_rnd;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [127:0] sr_d;
    logic [127:0] mc_d;
    logic [127:0] round_d;
    logic [127:0] final_d;

    // Byte b sits at [127-8b -: 8] with row = b%4, column = b/4; row r rotates left by r columns.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign sr_d[127-8*gi -: 8] = sbox(blk_q[127-8*SRC -: 8]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr_d[127-32*gi -: 8];
            assign a1 = sr_d[119-32*gi -: 8];
            assign a2 = sr_d[111-32*gi -: 8];
            assign a3 = sr_d[103-32*gi -: 8];
            assign mc_d[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc_d[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc_d[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc_d[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    assign round_d = mc_d ^ round_key_i;
    assign final_d = sr_d ^ round_key_i;

`ifdef AES_ENC_MODE256_EN
    logic [3:0] nr_q;
    logic [3:0] nr_sel;

    always_comb begin
        nr_sel = 4'd10;
        case (mode_i)
            2'd1:    nr_sel = 4'd12;
            2'd2:    nr_sel = 4'd14;
            default: nr_sel = 4'd10;
        endcase
    end

    assign nr_cur   = nr_q;
    assign last_rnd = nr_q - 4'd1;
`else
    logic unused_mode;
    assign unused_mode = ^mode_i;
    assign nr_cur      = 4'd10;
    assign last_rnd    = 4'd9;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q    <= S_IDLE;
            blk_q    <= '0;
            cipher_q <= '0;
            rnd_q    <= '0;
            done_q   <= 1'b0;
`ifdef AES_ENC_MODE256_EN
            nr_q     <= 4'd10;
`endif
        end else if (abort_i) begin
            fsm_q    <= S_IDLE;
            cipher_q <= '0;
            rnd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (start_i) begin
                        blk_q <= plain_i ^ round_key_i;
                        rnd_q <= 4'd1;
                        fsm_q <= S_ROUND;
`ifdef AES_ENC_MODE256_EN
                        nr_q  <= nr_sel;
`endif
                    end
                end
                S_ROUND: begin
                    blk_q <= round_d;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == last_rnd) fsm_q <= S_FINAL;
                end
                S_FINAL: begin
                    cipher_q <= final_d;
                    done_q   <= 1'b1;
                    fsm_q    <= S_IDLE;
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        key_idx_o = 4'd0;
        case (fsm_q)
            S_ROUND: key_idx_o = rnd_q;
            S_FINAL: key_idx_o = nr_cur;
            default: key_idx_o = 4'd0;
        endcase
    end

    assign busy_o   = (fsm_q != S_IDLE);
    assign ready_o  = !busy_o;
    assign done_o   = done_q;
    assign cipher_o = cipher_q;

endmodule

// File: tb/tb_enc_round_engine.sv
// Directed bench for enc_round_engine with a behavioural expanded-key store driven from key_idx.
`timescale 1ns/1ps
module tb_enc_round_engine;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [1:0]   mode;
    logic [127:0] plain;
    logic [127:0] round_key;
    logic [3:0]   key_idx;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] cipher;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K_128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K_B    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic [127:0] rk_tab [0:14];
    int           log_t  [0:255];
    logic [7:0]   alog_t [0:255];

    assign round_key = (key_idx <= 4'd14) ? rk_tab[key_idx] : 128'h0;

    enc_round_engine dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .mode_i      (mode),
        .plain_i     (plain),
        .round_key_i (round_key),
        .key_idx_o   (key_idx),
        .ready_o     (ready),
        .busy_o      (busy),
        .done_o      (done),
        .cipher_o    (cipher)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key-schedule S-box built from log/antilog tables over generator 03.
    function automatic logic [7:0] sbox_tb(input logic [7:0] x);
        logic [7:0] b;
        b = (x == 8'h00) ? 8'h00 : alog_t[(255 - log_t[x]) % 255];
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tb(w[31:24]), sbox_tb(w[23:16]), sbox_tb(w[15:8]), sbox_tb(w[7:0])};
    endfunction

    task automatic build_tables();
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog_t[i] = p;
            log_t[p]  = i;
            p = p ^ xt(p);
        end
        alog_t[255] = 8'h01;
        log_t[0]    = 0;
    endtask

    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nw;
        nw   = 4 * (nk + 7);
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk_tab[r] = (4*r + 3 < nw) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (cipher !== 128'h0) begin errors++; $display("FAIL reset_cipher: got %h expected 0", cipher); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (key_idx !== 4'd0)  begin errors++; $display("FAIL reset_key_idx: got %0d expected 0", key_idx); end
        rst = 1'b0;
        $display("reset: cipher=%h ready=%b busy=%b", cipher, ready, busy);
    endtask

    // One block from IDLE: key_idx walk, busy, single done at cycle lat, result and hold afterwards.
    task automatic test_block(input string name, input logic [1:0] m, input logic [127:0] pt,
                              input logic [127:0] exp, input int lat);
        int           ndone;
        int           done_at;
        logic [127:0] got;
        ndone = 0; done_at = -1; got = 'x;
        @(negedge clk);
        mode = m; plain = pt; start = 1'b1;
        checks++;
        if (ready !== 1'b1 || key_idx !== 4'd0) begin
            errors++; $display("FAIL %s_idle: got ready=%b key_idx=%0d expected ready=1 key_idx=0", name, ready, key_idx);
        end
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c < lat) begin
                checks++;
                if (key_idx !== c[3:0] || busy !== 1'b1) begin
                    errors++; $display("FAIL %s_key_idx_c%0d: got %0d busy=%b expected %0d busy=1", name, c, key_idx, busy, c);
                end
            end
            if (done === 1'b1) begin
                ndone++; done_at = c; got = cipher;
            end
        end
        checks += 4;
        if (ndone !== 1)    begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, ndone); end
        if (done_at !== lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, done_at, lat); end
        if (got !== exp)    begin errors++; $display("FAIL %s_cipher: got %h expected %h", name, got, exp); end
        if (cipher !== exp || busy !== 1'b0) begin
            errors++; $display("FAIL %s_hold: got %h busy=%b expected %h busy=0", name, cipher, busy, exp);
        end
        $display("%s: mode=%0d done_at=%0d cipher=%h", name, m, done_at, got);
    endtask

    task automatic test_aes128();
        load_key(K_128, 4);
        test_block("aes128_c1", 2'd0, PT_C, CT_128, 11);
        load_key(K_B, 4);
        test_block("aes128_b", 2'd0, PT_B, CT_B, 11);
        load_key(K_128, 4);
    endtask

    task automatic test_mode_select();
`ifdef AES_ENC_MODE256_EN
        load_key(K_192, 6);
        test_block("aes192", 2'd1, PT_C, CT_192, 13);
        load_key(K_256, 8);
        test_block("aes256", 2'd2, PT_C, CT_256, 15);
        load_key(K_128, 4);
        test_block("mode3_as_128", 2'd3, PT_C, CT_128, 11);
`else
        test_block("mode2_ignored", 2'd2, PT_C, CT_128, 11);
        test_block("mode1_ignored", 2'd1, PT_C, CT_128, 11);
`endif
    endtask

    task automatic test_start_ignored();
        int ndone;
        int done_at;
        ndone = 0; done_at = -1;
        @(negedge clk);
        mode = 2'd0; plain = PT_C; start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            start = (c == 5);
            plain = (c == 5) ? ~PT_C : PT_C;
            if (done === 1'b1) begin
                ndone++; done_at = c;
                checks++;
                if (cipher !== CT_128) begin errors++; $display("FAIL midstart_cipher: got %h expected %h", cipher, CT_128); end
            end
        end
        start = 1'b0;
        checks += 2;
        if (ndone !== 1)     begin errors++; $display("FAIL midstart_done_count: got %0d expected 1", ndone); end
        if (done_at !== 11)  begin errors++; $display("FAIL midstart_latency: got %0d expected 11", done_at); end
        $display("start_ignored: dones=%0d done_at=%0d", ndone, done_at);
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        @(negedge clk);
        mode = 2'd0; plain = PT_C; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == 4);
            if (c == 5) begin
                checks++;
                if (busy !== 1'b0 || ready !== 1'b1 || cipher !== 128'h0 || key_idx !== 4'd0) begin
                    errors++;
                    $display("FAIL abort_idle: got busy=%b ready=%b key_idx=%0d cipher=%h expected 0 1 0 0", busy, ready, key_idx, cipher);
                end
            end
            if (done === 1'b1) ndone++;
        end
        abort = 1'b0;
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        $display("abort: dones=%0d cipher=%h", ndone, cipher);
        test_block("after_abort", 2'd0, PT_C, CT_128, 11);
    endtask

    task automatic test_back_to_back();
        int first_at;
        int second_at;
        first_at = -1; second_at = -1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; mode = 2'd0; plain = PT_C; start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                if (first_at < 0) begin
                    first_at = c;
                    start = 1'b1;
                end else if (second_at < 0) begin
                    second_at = c;
                end
            end
            if (c < 11 || (first_at > 0 && second_at < 0)) begin
                checks++;
                if (cipher !== ((c < 11) ? 128'h0 : CT_128)) begin
                    errors++; $display("FAIL b2b_hold_c%0d: got %h expected %h", c, cipher, (c < 11) ? 128'h0 : CT_128);
                end
            end
        end
        start = 1'b0;
        checks += 3;
        if (first_at !== 11)  begin errors++; $display("FAIL b2b_first: got %0d expected 11", first_at); end
        if (second_at !== 22) begin errors++; $display("FAIL b2b_second: got %0d expected 22", second_at); end
        if (cipher !== CT_128) begin errors++; $display("FAIL b2b_cipher: got %h expected %h", cipher, CT_128); end
        $display("back_to_back: first=%0d second=%0d cipher=%h", first_at, second_at, cipher);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; plain = '0;
        for (int r = 0; r < 15; r++) rk_tab[r] = '0;
        build_tables();
        load_key(K_128, 4);
        test_reset();
        test_aes128();
        test_mode_select();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
